// File: rtl/tetris_pkg.sv
// tetris_pkg: definitions shared by the piece generator and its LFSR.
//   - NUM_TYPES_DEFAULT : default number of piece shapes
//   - PIECE_W           : width of piece index / rotation outputs
//   - LFSR_W, LFSR_TAPS, LFSR_SEED_DEFAULT : random source geometry
//   - CAND_W            : number of LFSR bits used as a piece candidate
//   - gen_state_e       : generator FSM states
//   - lfsr_advance()    : one Fibonacci LFSR step
package tetris_pkg;

    localparam int unsigned NUM_TYPES_DEFAULT = 5;
    localparam int unsigned PIECE_W           = 10;

    localparam int unsigned LFSR_W = 16;
    // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Candidates are drawn from the low bits; 3 bits cover up to 8 shapes.
    localparam int unsigned CAND_W = 3;

    typedef enum logic [1:0] {
        StFill,
        StReady,
        StActive
    } gen_state_e;

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/piece_lfsr.sv
// piece_lfsr: free-running 16-bit Fibonacci LFSR used as the piece source.
// It advances every clock, regardless of whether the generator consumes a value.
// Parameters:
//   SEED  : reset value (must be nonzero, an all-zero state never leaves zero)
//   OUT_W : number of low state bits exposed on rnd
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, loads SEED
//   rnd : low OUT_W bits of the current LFSR state
module piece_lfsr
    import tetris_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = LFSR_SEED_DEFAULT,
    parameter int unsigned       OUT_W = CAND_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_advance(lfsr_q);
        end
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/piece_gen.sv
// piece_gen: random piece generator with a one-deep preview queue.
// An LFSR supplies a candidate every cycle; while the preview slot is empty
// (StFill) acceptable candidates are loaded into next_num. A spawn request
// moves the preview into the active slot and refills the preview.
//
// Optional build macro PIECE_BAG_EN: bag randomizer. A used-mask rejects
// shapes already drawn in the current bag, so every aligned group of
// NUM_TYPES accepted pieces is a permutation of 0..NUM_TYPES-1.
//
// Parameters:
//   NUM_TYPES : number of shapes, valid indices 0..NUM_TYPES-1 (<= 8)
//   LFSR_SEED : LFSR reset value (nonzero)
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   spawn_req   : request a new active piece, held until spawn_ack
//   rot_req     : single-cycle request to rotate the active piece
//   spawn_ack   : combinational pulse in the cycle the spawn is taken
//   block_num   : active piece index (registered)
//   rotate      : raw rotation count, wraps at 10 bits (registered)
//   next_num    : preview of the queued next piece (registered)
//   piece_valid : an active piece exists (registered)
module piece_gen
    import tetris_pkg::*;
#(
    parameter int unsigned       NUM_TYPES = NUM_TYPES_DEFAULT,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spawn_req,
    input  logic               rot_req,
    output logic               spawn_ack,
    output logic [PIECE_W-1:0] block_num,
    output logic [PIECE_W-1:0] rotate,
    output logic [PIECE_W-1:0] next_num,
    output logic               piece_valid
);

    gen_state_e        state;
    logic [CAND_W-1:0] cand;
    logic              cand_in_range;
    logic              cand_ok;
    logic              spawn_fire;
    logic              rot_fire;

    piece_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (CAND_W)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (cand)
    );

    assign cand_in_range = 32'(cand) < NUM_TYPES;

`ifdef PIECE_BAG_EN
    logic [NUM_TYPES-1:0] used_q;
    logic [NUM_TYPES-1:0] used_eff;
    logic [NUM_TYPES-1:0] cand_bit;

    always_comb begin
        // Shifts out to zero for out-of-range candidates; cand_in_range gates those anyway.
        cand_bit = NUM_TYPES'(1) << cand;
        // A full bag reads as empty, so the acceptance that opens the next bag
        // both clears the old bits and records the new shape.
        used_eff = (&used_q) ? '0 : used_q;
        cand_ok  = cand_in_range && ((used_eff & cand_bit) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
        end else if (state == StFill && cand_ok) begin
            used_q <= used_eff | cand_bit;
        end
    end
`else
    assign cand_ok = cand_in_range;
`endif

    // Spawn is only possible once the preview is full; reset blocks it outright.
    assign spawn_fire = spawn_req && !rst && (state != StFill);
    assign spawn_ack  = spawn_fire;
    // A spawn in the same cycle takes precedence and drops the rotation.
    assign rot_fire   = rot_req && piece_valid && !spawn_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StFill;
            block_num   <= '0;
            rotate      <= '0;
            next_num    <= '0;
            piece_valid <= 1'b0;
        end else begin
            if (rot_fire) begin
                rotate <= rotate + PIECE_W'(1);
            end

            case (state)
                StFill: begin
                    if (cand_ok) begin
                        next_num <= PIECE_W'(cand);
                        state    <= piece_valid ? StActive : StReady;
                    end
                end
                StReady, StActive: begin
                    if (spawn_fire) begin
                        block_num   <= next_num;
                        rotate      <= '0;
                        piece_valid <= 1'b1;
                        state       <= StFill;
                    end
                end
                default: begin
                    state <= StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_gen.sv
// tb_piece_gen: self-checking bench for piece_gen.
// A behavioural reference model is stepped alongside the DUT; each step pushes
// its expected outputs onto a scoreboard queue, which is popped and compared
// once the DUT has clocked. Directed checks cover reset, rotation wrap,
// spawn/rotate collision and reset during fill. Honours PIECE_BAG_EN.
module tb_piece_gen;

    localparam int unsigned NT   = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       spawn_req;
    logic       rot_req;
    logic       spawn_ack;
    logic [9:0] block_num;
    logic [9:0] rotate;
    logic [9:0] next_num;
    logic       piece_valid;

    always #5 clk = ~clk;

    piece_gen #(
        .NUM_TYPES (NT),
        .LFSR_SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spawn_req   (spawn_req),
        .rot_req     (rot_req),
        .spawn_ack   (spawn_ack),
        .block_num   (block_num),
        .rotate      (rotate),
        .next_num    (next_num),
        .piece_valid (piece_valid)
    );

    typedef struct {
        logic       ack;
        logic [9:0] blk;
        logic [9:0] rot;
        logic [9:0] nxt;
        logic       vld;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [15:0] m_lfsr;
    logic        m_have_next;
    logic        m_valid;
    logic [9:0]  m_block;
    logic [9:0]  m_rot;
    logic [9:0]  m_next;
    logic [NT-1:0] m_used;
    logic        last_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    task automatic model_step(input logic sreq, input logic rreq, input logic r,
                              output exp_t e);
        logic [2:0] c;
        logic       ok;
`ifdef PIECE_BAG_EN
        logic [NT-1:0] eff;
`endif
        e.ack = !r && sreq && m_have_next;
        if (r) begin
            m_lfsr      = SEED;
            m_have_next = 1'b0;
            m_valid     = 1'b0;
            m_block     = '0;
            m_rot       = '0;
            m_next      = '0;
            m_used      = '0;
        end else begin
            c = m_lfsr[2:0];
            if (e.ack) begin
                m_block     = m_next;
                m_rot       = '0;
                m_valid     = 1'b1;
                m_have_next = 1'b0;
            end else begin
                if (rreq && m_valid) m_rot = m_rot + 10'd1;
                if (!m_have_next) begin
`ifdef PIECE_BAG_EN
                    eff = (m_used == {NT{1'b1}}) ? '0 : m_used;
                    ok  = (32'(c) < NT) && !eff[c];
`else
                    ok  = (32'(c) < NT);
`endif
                    if (ok) begin
                        m_next      = {7'd0, c};
                        m_have_next = 1'b1;
`ifdef PIECE_BAG_EN
                        m_used    = eff;
                        m_used[c] = 1'b1;
`endif
                    end
                end
            end
            m_lfsr = ref_lfsr(m_lfsr);
        end
        e.blk = m_block;
        e.rot = m_rot;
        e.nxt = m_next;
        e.vld = m_valid;
    endtask

    // Called just after a falling edge: drive, check ack, clock, check registers.
    task automatic step(input logic sreq, input logic rreq, input logic r);
        exp_t e;
        exp_t want;
        spawn_req = sreq;
        rot_req   = rreq;
        rst       = r;
        model_step(sreq, rreq, r, e);
        sb.push_back(e);
        #1;
        last_ack = spawn_ack;
        check("spawn_ack", 32'(spawn_ack), 32'(sb[$].ack));
        @(negedge clk);
        want = sb.pop_front();
        check("block_num",   32'(block_num),   32'(want.blk));
        check("rotate",      32'(rotate),      32'(want.rot));
        check("next_num",    32'(next_num),    32'(want.nxt));
        check("piece_valid", 32'(piece_valid), 32'(want.vld));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_block"}, 32'(block_num),   0);
        check({tag, "_rot"},   32'(rotate),      0);
        check({tag, "_next"},  32'(next_num),    0);
        check({tag, "_valid"}, 32'(piece_valid), 0);
    endtask

    // Hold spawn_req until acknowledged or the budget runs out.
    task automatic spawn_wait(input int budget, input string tag);
        int n;
        n = 0;
        last_ack = 1'b0;
        while (!last_ack && n < budget) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (!last_ack) check({tag, "_timeout"}, 0, 1);
    endtask

    logic [9:0] got_pieces [10];
    logic [9:0] exp_blk;
    int         acks;
    int         cnt;
    int         n;

    initial begin
        spawn_req = 1'b0;
        rot_req   = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        // Reset values and rotation without a piece.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_reset_outputs("reset");
        check("reset_ack", 32'(spawn_ack), 0);
        step(1'b0, 1'b1, 1'b0);
        // Seed low bits are 3'b001, accepted on the first cycle.
        check("first_next", 32'(next_num), 1);
        check("rot_no_piece", 32'(rotate), 0);
        step(1'b0, 1'b1, 1'b0);
        check("rot_no_piece2", 32'(rotate), 0);

        // Spawn held from the first cycle after reset.
        step(1'b0, 1'b0, 1'b1);
        acks = 0;
        spawn_wait(64, "spawn0");
        if (last_ack) acks++;
        check("spawn0_block", 32'(block_num), 1);
        check("spawn0_rot", 32'(rotate), 0);
        check("spawn0_valid", 32'(piece_valid), 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (last_ack) acks++;
        end
        check("ack_once", acks, 1);

        // Rotation wrap: 1025 pulses.
        for (int i = 1; i <= 1025; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 1023) check("rot_1023", 32'(rotate), 1023);
            if (i == 1024) check("rot_wrap", 32'(rotate), 0);
            if (i == 1025) check("rot_1025", 32'(rotate), 1);
            step(1'b0, 1'b0, 1'b0);
        end

        // Spawn and rotate on the same edge with rotate == 3.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rot_3", 32'(rotate), 3);
        n = 0;
        while (!m_have_next && n < 64) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        exp_blk = m_next;
        step(1'b1, 1'b1, 1'b0);
        check("collide_ack", 32'(last_ack), 1);
        check("collide_rot", 32'(rotate), 0);
        check("collide_block", 32'(block_num), 32'(exp_blk));

        // Reset while in fill with a spawn pending.
        step(1'b1, 1'b0, 1'b1);
        check("rst_fill_ack", 32'(last_ack), 0);
        check_reset_outputs("rst_fill");

        // Reset while ready with a spawn pending must also suppress the ack.
        n = 0;
        while (!m_have_next && n < 64) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        step(1'b1, 1'b0, 1'b1);
        check("rst_ready_ack", 32'(last_ack), 0);
        check_reset_outputs("rst_ready");

        // Ten consecutive spawns from a fresh reset.
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            spawn_wait(256, "bag_spawn");
            got_pieces[k] = block_num;
        end
`ifdef PIECE_BAG_EN
        for (int g = 0; g < 2; g++) begin
            for (int v = 0; v < 5; v++) begin
                cnt = 0;
                for (int j = 0; j < 5; j++) begin
                    if (got_pieces[g * 5 + j] == 10'(v)) cnt++;
                end
                check("bag_perm", cnt, 1);
            end
        end
`else
        for (int k = 0; k < 10; k++) begin
            check("piece_range", 32'(got_pieces[k] < 10'd5), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
